conv_mem_responder: RTL and testbench
=====================================

// Module: conv_mem_responder
// PURPOSE
// Memory-side responder for the CONV engine's image/layer interface. It holds the 64x64 input image,
// the layer-0 result (4096 words) and the layer-1 result (1024 words). It answers iaddr/caddr_rd
// reads and cwr writes, and drives the ready start handshake. It sits between the stimulus loader
// and CONV, and flags the end of the run for the system/bench.
// PARAMETERS
// DW        20    data word width (image and layer words)
// AW        12    address width of iaddr/caddr_rd/caddr_wr
// IMG_DEPTH 4096  image words loaded before ready is raised
// L1_DEPTH  1024  layer-1 (max-pool) memory depth
// PORTS
// clk       in   1   rising-edge clock
// reset     in   1   synchronous, active-high reset
// ld_valid  in   1   image-load word strobe
// ld_data   in   DW  image-load word, written at sequential addresses 0..IMG_DEPTH-1
// ld_ready  out  1   high while load words are accepted (state LOAD)
// ready     out  1   start request to CONV
// busy      in   1   CONV busy
// iaddr     in   AW  image read address
// idata     out  DW  image read data, combinational from iaddr
// cwr       in   1   layer write enable
// caddr_wr  in   AW  layer write address
// cdata_wr  in   DW  layer write data
// crd       in   1   layer read enable
// caddr_rd  in   AW  layer read address
// cdata_rd  out  DW  layer read data, combinational
// csel      in   3   layer select: 1=L0, 3=L1; any other value is ignored
// done      out  1   sticky: CONV run finished
// err       out  1   sticky: L1 access with address >= L1_DEPTH, or cwr&&crd on the same memory
// wr_cnt    out  13  accepted layer writes since the last load started
// BEHAVIOUR
// - Reset values: ld_ready=0, ready=0, done=0, err=0, wr_cnt=0, state=IDLE.
//   Memory contents are not cleared by reset.
// - FSM states: IDLE, LOAD, START, RUN, FINISH.
//   - IDLE -> LOAD the cycle after reset deasserts. The load pointer is cleared.
//   - LOAD: ld_ready=1.
//     - Each ld_valid cycle writes ld_data to image[ptr] and then ptr+1.
//     - The cycle that writes ptr=IMG_DEPTH-1 moves to START.
//     - Gaps in ld_valid are allowed.
//   - START: ready=1 for exactly one cycle, then RUN. ready is registered; it is never high in any
//     other state.
//   - RUN: waits for busy=1 and then busy=0 (edge-tracked with a registered busy_q).
//     - busy falling after it was seen high -> FINISH.
//     - busy high on the first RUN cycle counts as seen.
//   - FINISH: done=1 (sticky). ld_valid=1 here restarts the FSM: ptr=0, done/err/wr_cnt cleared,
//     and that word is stored at address 0 (LOAD entered with ptr=1).
// - Reads are asynchronous (zero latency): idata=image[iaddr].
//   cdata_rd = L0[caddr_rd] when csel=1, L1[caddr_rd] when csel=3 and addr < L1_DEPTH, else 0.
//   The crd level does not gate the data; crd is used only for err checks.
// - Writes: at posedge with cwr=1 and state RUN.
//   - csel=1: L0[caddr_wr] <= cdata_wr.
//   - csel=3 and addr < L1_DEPTH: L1 written.
//   - Each accepted write increments wr_cnt (saturates at 8191). Writes outside RUN are dropped.
// - Same-cycle read/write of one address returns the old word; the new word is visible the
//   following cycle.
// - err sets on:
//   - csel=3 with cwr or crd and the address >= L1_DEPTH (write dropped);
//   - cwr=1 and crd=1 with the same csel in one cycle (the write still happens).
// - Reset mid-load or mid-run returns to IDLE and then reloads from address 0. Partially written
//   memories keep their stale contents.
// TESTING
// 1. Reset, stream 4096 words with data=addr:
//    - ld_ready is high for the whole load;
//    - ready pulses once, exactly 1 cycle after the last word;
//    - idata at iaddr=0x0A5 reads 0x000A5 in the same cycle.
// 2. In RUN, csel=1, cwr=1, addr 0x041, data 0x12345:
//    - the next cycle, caddr_rd=0x041, csel=1 gives cdata_rd=0x12345;
//    - wr_cnt=1.
// 3. csel=3 write at 0x3FF succeeds; csel=3 write at 0x400:
//    - that write is dropped;
//    - err=1;
//    - L1[0x3FF] is unchanged by the dropped write.
// 4. busy 0->1 held 50 cycles, then 1->0: done rises the cycle after the fall and stays high.
// 5. csel=2 write plus a write while in LOAD: memories are unchanged and wr_cnt is not incremented.
// 6. Assert reset at word 2000 of the load:
//    - ready never pulses;
//    - the reload of 4096 words gives a ready pulse;
//    - image[0] holds the new data.

Source files
------------

// File: rtl/conv_mem_responder.sv
// Memory-side responder for CONV: image, layer-0 and layer-1 stores with asynchronous reads,
// plus the load -> start -> run -> finish sequencing that loads the image and hands off to CONV.
module conv_mem_responder #(
  parameter int DW        = 20,
  parameter int AW        = 12,
  parameter int IMG_DEPTH = 4096,
  parameter int L1_DEPTH  = 1024
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          ld_valid,
  input  logic [DW-1:0] ld_data,
  output logic          ld_ready,
  output logic          ready,
  input  logic          busy,
  input  logic [AW-1:0] iaddr,
  output logic [DW-1:0] idata,
  input  logic          cwr,
  input  logic [AW-1:0] caddr_wr,
  input  logic [DW-1:0] cdata_wr,
  input  logic          crd,
  input  logic [AW-1:0] caddr_rd,
  output logic [DW-1:0] cdata_rd,
  input  logic [2:0]    csel,
  output logic          done,
  output logic          err,
  output logic [12:0]   wr_cnt
);
  localparam int            L1AW     = $clog2(L1_DEPTH);
  localparam logic [AW-1:0] LAST_PTR = AW'(IMG_DEPTH - 1);
  localparam logic [AW-1:0] L1_LIMIT = AW'(L1_DEPTH);
  localparam logic [12:0]   CNT_MAX  = 13'h1FFF;

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_START, S_RUN, S_FINISH} state_t;

  state_t        r_state;
  logic [AW-1:0] r_ptr;
  logic          r_ld_ready;
  logic          r_ready;
  logic          r_done;
  logic          r_err;
  logic          r_busy_q;
  logic [12:0]   r_wr_cnt;

  logic [DW-1:0] r_img [0:IMG_DEPTH-1];
  logic [DW-1:0] r_l0  [0:IMG_DEPTH-1];
  logic [DW-1:0] r_l1  [0:L1_DEPTH-1];

  logic          w_sel_l0;
  logic          w_sel_l1;
  logic          w_wr_in_l1;
  logic          w_rd_in_l1;
  logic          w_restart;
  logic          w_img_we;
  logic [AW-1:0] w_img_addr;
  logic          w_l0_we;
  logic          w_l1_we;
  logic          w_err_evt;

  assign w_sel_l0   = (csel == 3'd1);
  assign w_sel_l1   = (csel == 3'd3);
  assign w_wr_in_l1 = (caddr_wr < L1_LIMIT);
  assign w_rd_in_l1 = (caddr_rd < L1_LIMIT);

  // A load word arriving in FINISH restarts the run and lands at address 0 immediately.
  assign w_restart  = (r_state == S_FINISH) && ld_valid;
  assign w_img_we   = !reset && (((r_state == S_LOAD) && ld_valid) || w_restart);
  assign w_img_addr = w_restart ? '0 : r_ptr;
  assign w_l0_we    = !reset && cwr && (r_state == S_RUN) && w_sel_l0;
  assign w_l1_we    = !reset && cwr && (r_state == S_RUN) && w_sel_l1 && w_wr_in_l1;
  assign w_err_evt  = (w_sel_l1 && ((cwr && !w_wr_in_l1) || (crd && !w_rd_in_l1))) ||
                      (cwr && crd && (w_sel_l0 || w_sel_l1));

  always_ff @(posedge clk) begin
    if (w_img_we) r_img[w_img_addr] <= ld_data;
  end

  always_ff @(posedge clk) begin
    if (w_l0_we) r_l0[caddr_wr] <= cdata_wr;
  end

  always_ff @(posedge clk) begin
    if (w_l1_we) r_l1[caddr_wr[L1AW-1:0]] <= cdata_wr;
  end

  // Zero-latency reads: a same-cycle write is only visible after the edge.
  assign idata = r_img[iaddr];

  always_comb begin
    cdata_rd = '0;
    if (w_sel_l0)
      cdata_rd = r_l0[caddr_rd];
    else if (w_sel_l1 && w_rd_in_l1)
      cdata_rd = r_l1[caddr_rd[L1AW-1:0]];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_ptr      <= '0;
      r_ld_ready <= 1'b0;
      r_ready    <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
      r_busy_q   <= 1'b0;
      r_wr_cnt   <= '0;
    end else begin
      r_ready <= 1'b0;
      if (w_err_evt) r_err <= 1'b1;
      if ((w_l0_we || w_l1_we) && (r_wr_cnt != CNT_MAX)) r_wr_cnt <= r_wr_cnt + 13'd1;
      case (r_state)
        S_IDLE: begin
          r_state    <= S_LOAD;
          r_ptr      <= '0;
          r_ld_ready <= 1'b1;
        end
        S_LOAD: begin
          if (ld_valid) begin
            r_ptr <= r_ptr + 1'b1;
            if (r_ptr == LAST_PTR) begin
              r_state    <= S_START;
              r_ready    <= 1'b1;
              r_ld_ready <= 1'b0;
            end
          end
        end
        S_START: begin
          r_state  <= S_RUN;
          r_busy_q <= 1'b0;
        end
        S_RUN: begin
          // busy high on the first RUN cycle is captured here, so its fall still counts.
          r_busy_q <= busy;
          if (r_busy_q && !busy) begin
            r_state <= S_FINISH;
            r_done  <= 1'b1;
          end
        end
        S_FINISH: begin
          if (ld_valid) begin
            r_state    <= S_LOAD;
            r_ptr      <= {{(AW-1){1'b0}}, 1'b1};
            r_ld_ready <= 1'b1;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
            r_wr_cnt   <= '0;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign ld_ready = r_ld_ready;
  assign ready    = r_ready;
  assign done     = r_done;
  assign err      = r_err;
  assign wr_cnt   = r_wr_cnt;

endmodule

// File: tb/tb_conv_mem_responder.sv
// Scoreboard bench for conv_mem_responder: stimulus pushes expected observations computed from a
// plain array model; a negedge monitor pops and compares them and checks every ready pulse.
module tb_conv_mem_responder;
  localparam int DW  = 20;
  localparam int AW  = 12;
  localparam int IMG = 4096;
  localparam int L1D = 1024;

  localparam int S_IDATA = 0;
  localparam int S_CRD   = 1;
  localparam int S_CNT   = 2;
  localparam int S_ERR   = 3;
  localparam int S_DONE  = 4;
  localparam int S_LDR   = 5;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          ld_valid = 1'b0;
  logic [DW-1:0] ld_data = '0;
  logic          ld_ready;
  logic          ready;
  logic          busy = 1'b0;
  logic [AW-1:0] iaddr = '0;
  logic [DW-1:0] idata;
  logic          cwr = 1'b0;
  logic [AW-1:0] caddr_wr = '0;
  logic [DW-1:0] cdata_wr = '0;
  logic          crd = 1'b0;
  logic [AW-1:0] caddr_rd = '0;
  logic [DW-1:0] cdata_rd;
  logic [2:0]    csel = '0;
  logic          done;
  logic          err;
  logic [12:0]   wr_cnt;

  conv_mem_responder #(.DW(DW), .AW(AW), .IMG_DEPTH(IMG), .L1_DEPTH(L1D)) dut (
    .clk(clk), .reset(reset), .ld_valid(ld_valid), .ld_data(ld_data), .ld_ready(ld_ready),
    .ready(ready), .busy(busy), .iaddr(iaddr), .idata(idata), .cwr(cwr), .caddr_wr(caddr_wr),
    .cdata_wr(cdata_wr), .crd(crd), .caddr_rd(caddr_rd), .cdata_rd(cdata_rd), .csel(csel),
    .done(done), .err(err), .wr_cnt(wr_cnt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference model: memories as arrays, plus the externally visible counters/flags.
  logic [DW-1:0] m_img [IMG];
  logic [DW-1:0] m_l0  [IMG];
  logic [DW-1:0] m_l1  [L1D];
  bit            v_l0  [IMG];
  bit            v_l1  [L1D];
  int            m_cnt = 0;
  bit            m_err = 1'b0;
  bit            m_run = 1'b0;

  typedef struct packed {
    logic [3:0]  sig;
    logic [7:0]  tid;
    logic [31:0] val;
    logic [31:0] at;
  } exp_t;

  exp_t sb[$];
  int   ready_q[$];
  int   n_chk = 0;
  int   n_pass = 0;
  int   tid = 0;

  function automatic string sname(input logic [3:0] s);
    case (s)
      4'd0:    return "idata";
      4'd1:    return "cdata_rd";
      4'd2:    return "wr_cnt";
      4'd3:    return "err";
      4'd4:    return "done";
      4'd5:    return "ld_ready";
      default: return "unknown";
    endcase
  endfunction

  function automatic logic [31:0] observe(input logic [3:0] s);
    case (s)
      4'd0:    return 32'(idata);
      4'd1:    return 32'(cdata_rd);
      4'd2:    return 32'(wr_cnt);
      4'd3:    return 32'(err);
      4'd4:    return 32'(done);
      4'd5:    return 32'(ld_ready);
      default: return 32'hFFFF_FFFF;
    endcase
  endfunction

  task automatic expect_sig(input int sig, input logic [31:0] val);
    exp_t e;
    e.sig = 4'(sig);
    e.tid = 8'(tid);
    e.val = val;
    e.at  = 32'(cyc);
    sb.push_back(e);
  endtask

  always @(negedge clk) begin
    exp_t        e;
    logic [31:0] got;
    while (sb.size() > 0 && sb[0].at <= 32'(cyc)) begin
      e   = sb.pop_front();
      got = observe(e.sig);
      n_chk++;
      if (e.at != 32'(cyc) || got !== e.val)
        $display("FAIL t%0d %s cyc=%0d got=0x%0h want=0x%0h", e.tid, sname(e.sig), cyc, got, e.val);
      else
        n_pass++;
    end
    if (ready === 1'b1) begin
      n_chk++;
      if (ready_q.size() == 0)
        $display("FAIL t%0d ready_unexpected cyc=%0d got=1 want=0", tid, cyc);
      else if (ready_q[0] != cyc)
        $display("FAIL t%0d ready_cycle got=%0d want=%0d", tid, cyc, ready_q.pop_front());
      else begin
        void'(ready_q.pop_front());
        n_pass++;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic quiet();
    cwr = 1'b0; crd = 1'b0; ld_valid = 1'b0; csel = 3'd0;
  endtask

  // One clock; the model absorbs whatever the DUT should have committed at that edge.
  task automatic step();
    bit was_run;
    was_run = m_run;
    tick();
    if (cwr && was_run) begin
      if (csel == 3'd1) begin
        m_l0[caddr_wr] = cdata_wr; v_l0[caddr_wr] = 1'b1;
        if (m_cnt < 8191) m_cnt++;
      end else if (csel == 3'd3 && int'(caddr_wr) < L1D) begin
        m_l1[int'(caddr_wr)] = cdata_wr; v_l1[int'(caddr_wr)] = 1'b1;
        if (m_cnt < 8191) m_cnt++;
      end
    end
    if (csel == 3'd3 && ((cwr && int'(caddr_wr) >= L1D) || (crd && int'(caddr_rd) >= L1D))) m_err = 1'b1;
    if (cwr && crd && (csel == 3'd1 || csel == 3'd3)) m_err = 1'b1;
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1;
    quiet();
    repeat (n) tick();
    m_cnt = 0; m_err = 1'b0; m_run = 1'b0;
    expect_sig(S_LDR, 0); expect_sig(S_DONE, 0); expect_sig(S_ERR, 0); expect_sig(S_CNT, 0);
    reset = 1'b0;
    tick();
  endtask

  task automatic load_words(input int first, input int last, input bit addr_data, input bit noise);
    for (int a = first; a <= last; a++) begin
      while ($urandom_range(0, 7) == 0) begin
        ld_valid = 1'b0; cwr = 1'b0;
        expect_sig(S_LDR, 1);
        step();
      end
      ld_valid = 1'b1;
      ld_data  = addr_data ? DW'(a) : DW'($urandom);
      if (noise) begin
        cwr = 1'($urandom_range(0, 1)); csel = 3'd1;
        caddr_wr = AW'($urandom_range(0, 31)); cdata_wr = DW'($urandom);
      end
      expect_sig(S_LDR, 1);
      step();
      m_img[a] = ld_data;
    end
    ld_valid = 1'b0; cwr = 1'b0;
    if (last == IMG - 1) begin
      ready_q.push_back(cyc);
      expect_sig(S_LDR, 0);
    end
  endtask

  task automatic enter_run();
    step();
    m_run = 1'b1;
  endtask

  task automatic rand_op();
    int k;
    k = $urandom_range(0, 5);
    csel = (k < 3) ? 3'd1 : (k < 5) ? 3'd3 : 3'($urandom_range(0, 7));
    cwr = 1'($urandom_range(0, 1));
    crd = 1'($urandom_range(0, 1));
    cdata_wr = DW'($urandom);
    caddr_wr = (csel == 3'd3) ? AW'($urandom_range(1008, 1039)) : AW'($urandom_range(0, 31));
    caddr_rd = (csel == 3'd3) ? AW'($urandom_range(1008, 1039)) : AW'($urandom_range(0, 31));
    iaddr = AW'($urandom);
    expect_sig(S_IDATA, 32'(m_img[iaddr]));
    if (csel == 3'd1) begin
      if (v_l0[caddr_rd]) expect_sig(S_CRD, 32'(m_l0[caddr_rd]));
    end else if (csel == 3'd3 && int'(caddr_rd) < L1D) begin
      if (v_l1[int'(caddr_rd)]) expect_sig(S_CRD, 32'(m_l1[int'(caddr_rd)]));
    end else
      expect_sig(S_CRD, 0);
    step();
    expect_sig(S_CNT, 32'(m_cnt));
    expect_sig(S_ERR, 32'(m_err));
  endtask

  task automatic busy_finish(input int hold);
    quiet();
    busy = 1'b1;
    repeat (hold) begin
      expect_sig(S_DONE, 0);
      step();
    end
    busy = 1'b0;
    expect_sig(S_DONE, 0);
    step();
    m_run = 1'b0;
    repeat (4) begin
      expect_sig(S_DONE, 1);
      step();
    end
  endtask

  task automatic restart();
    quiet();
    ld_valid = 1'b1;
    ld_data  = DW'($urandom);
    expect_sig(S_DONE, 1);
    step();
    m_img[0] = ld_data; m_cnt = 0; m_err = 1'b0;
    ld_valid = 1'b0;
    expect_sig(S_DONE, 0); expect_sig(S_ERR, 0); expect_sig(S_CNT, 0); expect_sig(S_LDR, 1);
  endtask

  initial begin
    // Reset and a full data=addr image load.
    tid = 1;
    do_reset(3);
    load_words(0, IMG - 1, 1'b1, 1'b0);
    enter_run();
    iaddr = 12'h0A5;
    expect_sig(S_IDATA, 32'h000A5);
    step();

    // First layer-0 write and read-back; then same-cycle read of a word being rewritten.
    tid = 2;
    cwr = 1'b1; csel = 3'd1; caddr_wr = 12'h041; cdata_wr = 20'h12345;
    step();
    cwr = 1'b0; caddr_rd = 12'h041;
    expect_sig(S_CRD, 32'h12345); expect_sig(S_CNT, 1); expect_sig(S_ERR, 0);
    step();
    cwr = 1'b1; cdata_wr = 20'h54321;
    expect_sig(S_CRD, 32'h12345);
    step();
    cwr = 1'b0;
    expect_sig(S_CRD, 32'h54321); expect_sig(S_CNT, 2);
    step();

    // Layer-1 boundary: last legal address accepted, first illegal one dropped with err.
    tid = 3;
    cwr = 1'b1; csel = 3'd3; caddr_wr = 12'h3FF; cdata_wr = 20'hABCDE;
    step();
    expect_sig(S_ERR, 0); expect_sig(S_CNT, 3);
    caddr_wr = 12'h400; cdata_wr = 20'h11111;
    step();
    cwr = 1'b0; caddr_rd = 12'h3FF;
    expect_sig(S_ERR, 1); expect_sig(S_CNT, 3); expect_sig(S_CRD, 32'hABCDE);
    step();
    caddr_rd = 12'h400;
    expect_sig(S_CRD, 0);
    step();
    repeat (150) rand_op();

    // busy 0->1 for 50 cycles then 1->0.
    tid = 4;
    busy_finish(50);

    // Writes in FINISH and during the reload are dropped; csel=2 is ignored in RUN.
    tid = 5;
    cwr = 1'b1; csel = 3'd1; caddr_wr = 12'h041; cdata_wr = 20'h0FFFF;
    step();
    cwr = 1'b0; caddr_rd = 12'h041;
    expect_sig(S_CRD, 32'(m_l0[12'h041])); expect_sig(S_CNT, 32'(m_cnt));
    step();
    restart();
    load_words(1, IMG - 1, 1'b0, 1'b1);
    expect_sig(S_CNT, 0);
    enter_run();
    busy = 1'b1;
    cwr = 1'b1; csel = 3'd2; caddr_wr = 12'h041; cdata_wr = 20'h77777; caddr_rd = 12'h041;
    expect_sig(S_CRD, 0);
    step();
    cwr = 1'b0; csel = 3'd1;
    expect_sig(S_CNT, 0); expect_sig(S_CRD, 32'(m_l0[12'h041])); expect_sig(S_ERR, 0);
    step();
    cwr = 1'b1; crd = 1'b1; caddr_wr = 12'h010; cdata_wr = DW'($urandom); caddr_rd = 12'h020;
    step();
    cwr = 1'b0; crd = 1'b0; caddr_rd = 12'h010;
    expect_sig(S_ERR, 1); expect_sig(S_CNT, 1); expect_sig(S_CRD, 32'(m_l0[12'h010]));
    step();
    repeat (100) rand_op();
    busy_finish(0);

    // Reset part-way through a reload, then a clean reload.
    tid = 6;
    restart();
    load_words(1, 1999, 1'b0, 1'b0);
    do_reset(2);
    load_words(0, IMG - 1, 1'b0, 1'b0);
    enter_run();
    iaddr = 12'h000; csel = 3'd1; caddr_rd = 12'h041;
    expect_sig(S_IDATA, 32'(m_img[0])); expect_sig(S_CRD, 32'(m_l0[12'h041]));
    expect_sig(S_CNT, 0); expect_sig(S_ERR, 0);
    step();

    // Out-of-range layer-1 read flags err; wr_cnt saturation.
    tid = 7;
    crd = 1'b1; csel = 3'd3; caddr_rd = 12'h401;
    expect_sig(S_CRD, 0);
    step();
    crd = 1'b0;
    expect_sig(S_ERR, 1);
    step();
    for (int i = 0; i < 8196; i++) begin
      cwr = 1'b1; csel = 3'd1; caddr_wr = AW'(i % 32); cdata_wr = DW'($urandom);
      step();
      if (i % 1024 == 0 || i > 8185) expect_sig(S_CNT, 32'(m_cnt));
    end
    cwr = 1'b0;
    expect_sig(S_CNT, 32'h1FFF);
    step();
    busy_finish(1);

    @(negedge clk);
    #1;
    n_chk++;
    if (ready_q.size() != 0 || sb.size() != 0)
      $display("FAIL final_drain ready_left=%0d checks_left=%0d want=0", ready_q.size(), sb.size());
    else
      n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
